// File: rtl/multicycle_ctrl_param.sv
// Multicycle CPU control FSM: decodes op/op_ext into datapath selects and enables,
// with ready-handshaked memory states, a programmable WAIT delay and instruction-boundary halt.
module multicycle_ctrl_param #(
  parameter int unsigned WAIT_W       = 22,
  parameter int unsigned DEFAULT_WAIT = 2097152,
  parameter bit          MEM_HS       = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        op,
  input  logic [3:0]        op_ext,
  input  logic              branch,
  input  logic [WAIT_W-1:0] wait_count,
  input  logic              mem_ready,
  input  logic              halt_req,
  output logic [1:0]        WD_S,
  output logic [1:0]        ALUA_S,
  output logic [1:0]        ALUB_S,
  output logic [1:0]        MEM_DATA_S,
  output logic [1:0]        MEM_S,
  output logic              PC_S,
  output logic              PC_EN,
  output logic              REG_WR_EN,
  output logic              INSTR_EN,
  output logic              ALU_OUT_EN,
  output logic              MEM_REG_EN,
  output logic              MEM_WR_S,
  output logic              SE_SIGN,
  output logic              PSR_EN,
  output logic              halted,
  output logic [4:0]        state_o
);

  typedef enum logic [4:0] {
    S_FETCH      = 5'd0,
    S_DECODE     = 5'd1,
    S_RTYPE_EX   = 5'd2,
    S_ITYPE_EX   = 5'd3,
    S_WRITE      = 5'd4,
    S_LB_MEM     = 5'd5,
    S_LB_LOAD    = 5'd6,
    S_SB_MEM_R   = 5'd7,
    S_SB_MEM_I   = 5'd8,
    S_CALC_DISP  = 5'd9,
    S_PC_UP      = 5'd10,
    S_JUMP       = 5'd11,
    S_CALC_RLINK = 5'd12,
    S_WR_RLINK_J = 5'd13,
    S_PURGATORY  = 5'd14,
    S_WAIT       = 5'd15,
    S_HALT       = 5'd16
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] ctr, ctr_next;
  logic              fetch_stalled, fetch_stalled_next;
  logic              rdy;
  logic              halt_go;

  // Without the handshake every memory state completes in one cycle.
  assign rdy     = MEM_HS ? mem_ready : 1'b1;
  // Halt only before the fetch has started, so no fetched instruction is dropped.
  assign halt_go = halt_req && !fetch_stalled;
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_FETCH;
      ctr           <= '0;
      fetch_stalled <= 1'b0;
    end else begin
      state         <= state_next;
      ctr           <= ctr_next;
      fetch_stalled <= fetch_stalled_next;
    end
  end

  always_comb begin
    state_next         = state;
    ctr_next           = ctr;
    fetch_stalled_next = 1'b0;
    case (state)
      S_FETCH: begin
        if (halt_go) begin
          state_next = S_HALT;
        end else if (rdy) begin
          state_next = S_DECODE;
        end else begin
          fetch_stalled_next = 1'b1;
        end
      end
      S_DECODE: begin
        case (op)
          4'b0100: begin
            case (op_ext)
              4'b0100: state_next = S_SB_MEM_R;
              4'b0000: state_next = S_LB_MEM;
              4'b1100: state_next = branch ? S_JUMP : S_PC_UP;
              4'b1000: state_next = S_CALC_RLINK;
              default: state_next = S_PURGATORY;
            endcase
          end
          4'b0000: state_next = S_RTYPE_EX;
          4'b1000: state_next = (op_ext == 4'b0100) ? S_RTYPE_EX : S_ITYPE_EX;
          4'b1100: state_next = branch ? S_CALC_DISP : S_PC_UP;
          default: state_next = S_ITYPE_EX;
        endcase
      end
      S_RTYPE_EX: begin
        case (op_ext)
          4'b1011: state_next = S_PC_UP;
          4'b0000: begin
            state_next = S_WAIT;
            ctr_next   = (wait_count != '0) ? wait_count : WAIT_W'(DEFAULT_WAIT);
          end
          default: state_next = S_WRITE;
        endcase
      end
      S_ITYPE_EX: begin
        case (op)
          4'b1011: state_next = S_PC_UP;
          4'b0111: state_next = S_SB_MEM_I;
          default: state_next = S_WRITE;
        endcase
      end
      S_WAIT: begin
        // Counter value is the number of WAIT cycles still owed, including this one.
        if (ctr <= WAIT_W'(1)) state_next = S_PC_UP;
        if (ctr != '0) ctr_next = ctr - WAIT_W'(1);
      end
      S_LB_MEM:     if (rdy) state_next = S_LB_LOAD;
      S_SB_MEM_R:   if (rdy) state_next = S_PC_UP;
      S_SB_MEM_I:   if (rdy) state_next = S_PC_UP;
      S_WRITE:      state_next = S_PC_UP;
      S_LB_LOAD:    state_next = S_PC_UP;
      S_CALC_RLINK: state_next = S_WR_RLINK_J;
      S_CALC_DISP:  state_next = S_FETCH;
      S_JUMP:       state_next = S_FETCH;
      S_WR_RLINK_J: state_next = S_FETCH;
      S_PC_UP:      state_next = S_FETCH;
      S_PURGATORY:  state_next = S_PURGATORY;
      S_HALT:       state_next = halt_req ? S_HALT : S_FETCH;
      default:      state_next = S_FETCH;
    endcase
  end

  // Moore decode of the datapath controls; only INSTR_EN/MEM_REG_EN see mem_ready.
  // Held at defaults while reset is low so an aborted instruction writes nothing.
  always_comb begin
    WD_S       = 2'b00;
    ALUA_S     = 2'b00;
    ALUB_S     = 2'b00;
    MEM_DATA_S = 2'b00;
    MEM_S      = 2'b00;
    PC_S       = 1'b0;
    PC_EN      = 1'b0;
    REG_WR_EN  = 1'b0;
    INSTR_EN   = 1'b0;
    ALU_OUT_EN = 1'b0;
    MEM_REG_EN = 1'b0;
    MEM_WR_S   = 1'b0;
    SE_SIGN    = 1'b1;
    PSR_EN     = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          MEM_S    = 2'b01;
          INSTR_EN = rdy && !halt_go;
        end
        S_RTYPE_EX: begin
          ALU_OUT_EN = 1'b1;
          PSR_EN     = 1'b1;
        end
        S_ITYPE_EX: begin
          ALUA_S     = 2'b10;
          ALU_OUT_EN = 1'b1;
          PSR_EN     = 1'b1;
          SE_SIGN    = !(op == 4'b0001 || op == 4'b0010 || op == 4'b0011);
        end
        S_WRITE: begin
          WD_S      = 2'b11;
          REG_WR_EN = 1'b1;
        end
        S_LB_MEM: begin
          WD_S       = 2'b10;
          MEM_REG_EN = rdy;
        end
        S_LB_LOAD: begin
          WD_S      = 2'b10;
          REG_WR_EN = 1'b1;
        end
        S_SB_MEM_R: begin
          MEM_WR_S = 1'b1;
        end
        S_SB_MEM_I: begin
          MEM_S      = 2'b10;
          MEM_WR_S   = 1'b1;
          MEM_DATA_S = 2'b01;
        end
        S_CALC_DISP: begin
          ALUA_S = 2'b01;
          ALUB_S = 2'b01;
          PC_S   = 1'b1;
          PC_EN  = 1'b1;
        end
        S_PC_UP: begin
          ALUA_S = 2'b01;
          ALUB_S = 2'b10;
          PC_S   = 1'b1;
          PC_EN  = 1'b1;
        end
        S_JUMP: begin
          PC_EN = 1'b1;
        end
        S_CALC_RLINK: begin
          ALUA_S     = 2'b01;
          ALUB_S     = 2'b10;
          ALU_OUT_EN = 1'b1;
        end
        S_WR_RLINK_J: begin
          WD_S      = 2'b11;
          REG_WR_EN = 1'b1;
          PC_EN     = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
